interp_sched: RTL

Sequencer for the PVR plane-interpolator datapath. Accepts one triangle/tile job, runs each attribute (Z, U, V, shade, …) through the shared plane-setup unit one at a time and tells the coefficient store when to capture each result. It then steps the interpolator through the 32 rows of the 32×32 tile with a valid/ready span handshake. It sits between the triangle/tile fetch logic and the interpolator/span-consumer pair.

---
 rtl/pvr_interp_pkg.sv | 9 +
 rtl/interp_sched.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pvr_interp_pkg.sv
// Shared state type and tile geometry for the PVR plane-interpolator sequencer.
package pvr_interp_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SPAN, DONE} sched_state_t;

  localparam int TILE_DIM   = 32;
  localparam int TILE_SHIFT = 5;
  localparam int COORD_W    = 11;
  localparam int ATTR_SEL_W = 3;
endpackage

// File: rtl/interp_sched.sv
// Job sequencer: per-attribute plane setup with capture strobes, then one
// valid/ready span handshake per tile row.
module interp_sched
  import pvr_interp_pkg::*;
#(
  parameter int NUM_ATTR  = 4,
  parameter int SETUP_LAT = 2,
  parameter int TILE_ROWS = TILE_DIM
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [5:0]            tile_x,
  input  logic [5:0]            tile_y,
  input  logic                  flush,
  output logic [ATTR_SEL_W-1:0] attr_sel,
  output logic [NUM_ATTR-1:0]   cap_en,
  output logic [COORD_W-1:0]    x_ps,
  output logic [COORD_W-1:0]    y_ps,
  output logic                  span_valid,
  input  logic                  span_ready,
  output logic                  span_last,
  output logic                  job_done,
  output logic                  busy
);
  localparam logic [3:0]            LAT_LAST  = 4'(SETUP_LAT);
  localparam logic [ATTR_SEL_W-1:0] ATTR_LAST = ATTR_SEL_W'(NUM_ATTR - 1);
  localparam logic [TILE_SHIFT-1:0] ROW_LAST  = TILE_SHIFT'(TILE_ROWS - 1);

  sched_state_t          r_state, w_state_nxt;
  logic [ATTR_SEL_W-1:0] r_attr_idx, w_attr_nxt;
  logic [3:0]            r_wait_cnt, w_wait_nxt;
  logic [TILE_SHIFT-1:0] r_row, w_row_nxt;
  logic [5:0]            r_tile_x, w_tile_x_nxt;
  logic [5:0]            r_tile_y, w_tile_y_nxt;
  logic                  w_cap_slot;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_attr_idx <= '0;
      r_wait_cnt <= '0;
      r_row      <= '0;
      r_tile_x   <= '0;
      r_tile_y   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_attr_idx <= w_attr_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_row      <= w_row_nxt;
      r_tile_x   <= w_tile_x_nxt;
      r_tile_y   <= w_tile_y_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_attr_nxt   = r_attr_idx;
    w_wait_nxt   = r_wait_cnt;
    w_row_nxt    = r_row;
    w_tile_x_nxt = r_tile_x;
    w_tile_y_nxt = r_tile_y;
    case (r_state)
      IDLE: begin
        if (job_valid) begin
          w_tile_x_nxt = tile_x;
          w_tile_y_nxt = tile_y;
          w_attr_nxt   = '0;
          w_wait_nxt   = '0;
          w_row_nxt    = '0;
          w_state_nxt  = SETUP;
        end
      end
      SETUP: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (r_wait_cnt == LAT_LAST) begin
          w_wait_nxt = '0;
          if (r_attr_idx == ATTR_LAST) begin
            w_row_nxt   = '0;
            w_state_nxt = SPAN;
          end else begin
            w_attr_nxt = r_attr_idx + ATTR_SEL_W'(1);
          end
        end else begin
          w_wait_nxt = r_wait_cnt + 4'd1;
        end
      end
      SPAN: begin
        // An abort beats the final handshake, so no job_done for that job.
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (span_ready) begin
          if (r_row == ROW_LAST) w_state_nxt = DONE;
          else                   w_row_nxt   = r_row + TILE_SHIFT'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches an output directly.
  assign job_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign attr_sel   = r_attr_idx;
  assign x_ps       = {r_tile_x, {TILE_SHIFT{1'b0}}};
  assign y_ps       = {r_tile_y, {TILE_SHIFT{1'b0}}} + COORD_W'(r_row);
  assign span_valid = (r_state == SPAN);
  assign span_last  = span_valid && (r_row == ROW_LAST);
  assign job_done   = (r_state == DONE);
  assign w_cap_slot = (r_state == SETUP) && (r_wait_cnt == LAT_LAST);

  generate
    for (genvar gi = 0; gi < NUM_ATTR; gi++) begin : g_cap
      assign cap_en[gi] = w_cap_slot && (r_attr_idx == ATTR_SEL_W'(gi));
    end
  endgenerate
endmodule
